sgmii_link_monitor: RTL and testbench
=====================================

# sgmii_link_monitor

Parametrised, multi-channel link supervisor for the SGMII subsystem. It replaces the per-instance status wiring and the debug PIO with one CSR-mapped block. For each of `NUM_CH` SGMII PCS channels it debounces link state, decodes the speed straps, stretches activity for the panel LEDs and counts code-group errors. It raises one maskable interrupt toward the HPS on link changes and counter saturation.

## Interface
- `NUM_CH`, 2: number of SGMII channels, 1..8
- `DEBOUNCE_CYCLES`, 1250000: consecutive cycles a raw link change must persist (10 ms at 125 MHz)
- `STRETCH_CYCLES`, 6250000: activity LED on-time after last carrier-sense edge (50 ms)
- `CNT_W`, 16: error counter width, 1..32
- `csr_clk_clk`  in  1  sole clock; all inputs are synchronous to it (CDC is done upstream)
- `rst_in_reset_n`  in  1  reset, synchronous, active-low
- `sgmii_status_set_10/100/1000`  in  NUM_CH each  per-channel speed straps from the PCS
- `status_led_link`, `status_led_crs`, `status_led_an`, `status_led_char_err`, `status_led_disp_err`  in  NUM_CH each  raw PCS status
- `link_up`  out  NUM_CH  debounced link
- `speed_code`  out  2*NUM_CH  per-channel speed: 2'b00 10M, 01 100M, 10 1000M, 11 invalid
- `led_activity`  out  NUM_CH  stretched activity
- `irq`  out  1  level interrupt
- `csr_address`  in  6  word address
- `csr_read`, `csr_write`  in  1  Avalon-MM strobes
- `csr_writedata`  in  32  write data
- `csr_byteenable`  in  4  byte enables; a write takes effect only when all four bits are 1
- `csr_readdata`  out  32  read data
- `csr_readdatavalid`  out  1  read data valid
- `csr_waitrequest`  out  1  tied 0

## Operation
- **Debounce**
  - Per-channel counter counts while raw link ≠ `link_up`.
  - Counter clears on any cycle where raw link = `link_up`.
  - When the counter reaches `DEBOUNCE_CYCLES`, `link_up` toggles, the counter clears, and `INT_STATUS.link_chg[ch]` sets.
- **Speed decode**
  - Exactly one strap set gives its code.
  - Zero or several straps set give 2'b11.
- **Activity**
  - Each cycle with `crs`=1 loads the stretch counter with `STRETCH_CYCLES`.
  - `led_activity` = (counter ≠ 0). The counter decrements to 0.
- **Error counters**
  - `char_err` and `disp_err` each increment once per cycle the input is high.
  - Counters saturate at 2^CNT_W−1. On the saturating increment, `INT_STATUS.sat[ch]` sets.
- **CSR map** (words)
  - Per channel at ch*4:
    - +0 STATUS, RO: bit0 `link_up`, bits2:1 `speed_code`, bit3 `an`, bit4 `led_activity`.
    - +1 CHAR_ERR, RO; any full write clears it.
    - +2 DISP_ERR, same as +1.
    - +3 reserved, reads 0.
  - 0x20 INT_STATUS: bits[7:0] `link_chg`, bits[15:8] `sat`; W1C.
  - 0x21 INT_MASK: RW, reset 0.
  - Unmapped addresses and channels ≥ `NUM_CH` read 0; writes to them are ignored.
- `irq` = |(INT_STATUS & INT_MASK), registered.
- **Simultaneous events**
  - Counter clear and increment in the same cycle: clear wins; result 0.
  - Event set and W1C of the same bit in the same cycle: set wins.
  - Counter read in the same cycle as an increment: returns the pre-increment value.

## Timing
- **Reset values:** `link_up`=0, `speed_code`=2'b11, `led_activity`=0, `irq`=0, `csr_readdata`=0, `csr_readdatavalid`=0. All counters, INT_STATUS and INT_MASK are 0.
- **Reset mid-operation:** all state returns to reset values on the next edge; a pending read is dropped (no `readdatavalid`).
- **`speed_code`:** registered, 1-cycle latency from the straps.
- **Link change:** `link_up` changes exactly `DEBOUNCE_CYCLES` cycles after raw link first differs, if raw is held stable. The INT_STATUS bit sets on the same edge; `irq` follows 1 cycle later.
- **`led_activity`:** rises 1 cycle after `crs`. It falls `STRETCH_CYCLES` cycles after the last `crs`-high cycle.
- **Reads:** a read accepted at edge N gives `csr_readdatavalid`=1 and data at edge N+1, for one cycle. Back-to-back reads are allowed, one per cycle.
- **Writes:** take effect at the accepting edge. A read and a write in the same cycle is illegal; the write is performed and the read is ignored.

## Structure
- **Package `sgmii_mon_pkg`:**
  - speed code constants `SPD_10`, `SPD_100`, `SPD_1000`, `SPD_INV`
  - CSR offsets `OFS_STATUS`, `OFS_CHAR_ERR`, `OFS_DISP_ERR`, `ADDR_INT_STATUS`, `ADDR_INT_MASK`
  - `CH_STRIDE` = 4
- **Sub-module `sgmii_link_monitor_ch`:** one channel's debounce, speed decode, stretch and two counters. It emits event pulses and has a counter-clear input.
- **Top:** generate loop over channels, plus the CSR decode, INT_STATUS/INT_MASK and read pipeline.

## Test plan
All tests use `NUM_CH`=2, `DEBOUNCE_CYCLES`=8, `STRETCH_CYCLES`=5, `CNT_W`=4.
- **Debounce:** ch0 raw link high for 7 cycles, then low → `link_up` stays 0. Hold high for 8 cycles → `link_up`=1 at cycle 8. With INT_MASK=1, `irq`=1 on cycle 9.
- **Speed decode:** ch1 straps 100M only → `speed_code`[3:2]=01 after 1 cycle. Set both 10 and 1000 → 11.
- **Activity stretch:** one `crs` pulse → `led_activity` high exactly 5 cycles. A second pulse at cycle 3 extends it to cycle 8.
- **Saturation and clear:** 20 `char_err` cycles → CHAR_ERR reads 15 and `sat[0]` sets. A write to 0x01 in the same cycle as an error → reads 0.
- **W1C race:** write 0x20 = 0x1 on the cycle `link_chg[0]` sets → bit remains 1. A read of 0x20 returns 0x1 with `readdatavalid` on the next cycle.
- **Unmapped address and reset:** read 0x09 → 0. Assert reset during an outstanding read → no `readdatavalid`, all outputs at reset values.

Source files
------------

// File: rtl/sgmii_mon_pkg.sv
// Shared constants for the SGMII link monitor: speed codes, CSR layout and
// the strap decoder.
package sgmii_mon_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_INV  = 2'b11;

  localparam logic [1:0] OFS_STATUS   = 2'd0;
  localparam logic [1:0] OFS_CHAR_ERR = 2'd1;
  localparam logic [1:0] OFS_DISP_ERR = 2'd2;

  localparam logic [5:0] ADDR_INT_STATUS = 6'h20;
  localparam logic [5:0] ADDR_INT_MASK   = 6'h21;

  localparam int unsigned CH_STRIDE = 4;

  // Only a single asserted strap is a valid speed.
  function automatic logic [1:0] decode_speed(input logic s10, input logic s100,
                                              input logic s1000);
    case ({s1000, s100, s10})
      3'b001:  return SPD_10;
      3'b010:  return SPD_100;
      3'b100:  return SPD_1000;
      default: return SPD_INV;
    endcase
  endfunction

endpackage

// File: rtl/sgmii_link_monitor_ch.sv
// One SGMII channel: link debounce, speed decode, activity stretch and
// saturating code-group error counters with event pulses.
module sgmii_link_monitor_ch
  import sgmii_mon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned STRETCH_CYCLES  = 6250000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_raw,
  input  logic             set_10,
  input  logic             set_100,
  input  logic             set_1000,
  input  logic             crs,
  input  logic             char_err,
  input  logic             disp_err,
  input  logic             clr_char,
  input  logic             clr_disp,
  output logic             link_up,
  output logic [1:0]       speed_code,
  output logic             led_activity,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] disp_cnt,
  output logic             link_chg,
  output logic             sat
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]    STRETCH  = SW'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] act_cnt;
  logic          char_sat;
  logic          disp_sat;

  // Combinational pulse so the top can set INT_STATUS on the toggling edge.
  assign link_chg = (link_raw != link_up) && (deb_cnt == DEB_LAST);
  assign char_sat = char_err && !clr_char && (char_cnt == CNT_MAX - 1'b1);
  assign disp_sat = disp_err && !clr_disp && (disp_cnt == CNT_MAX - 1'b1);
  assign sat      = char_sat || disp_sat;
  assign led_activity = (act_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      link_up <= 1'b0;
    end else if (link_raw == link_up) begin
      deb_cnt <= '0;
    end else if (link_chg) begin
      deb_cnt <= '0;
      link_up <= ~link_up;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_code <= SPD_INV;
      act_cnt    <= '0;
    end else begin
      speed_code <= decode_speed(set_10, set_100, set_1000);
      if (crs)
        act_cnt <= STRETCH;
      else if (act_cnt != '0)
        act_cnt <= act_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_cnt <= '0;
      disp_cnt <= '0;
    end else begin
      if (clr_char)
        char_cnt <= '0;
      else if (char_err && char_cnt != CNT_MAX)
        char_cnt <= char_cnt + 1'b1;
      if (clr_disp)
        disp_cnt <= '0;
      else if (disp_err && disp_cnt != CNT_MAX)
        disp_cnt <= disp_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sgmii_link_monitor.sv
// Multi-channel SGMII link supervisor: per-channel monitors plus the
// Avalon-MM CSR decode, interrupt status/mask and registered read path.
module sgmii_link_monitor
  import sgmii_mon_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned STRETCH_CYCLES  = 6250000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                csr_clk_clk,
  input  logic                rst_in_reset_n,
  input  logic [NUM_CH-1:0]   sgmii_status_set_10,
  input  logic [NUM_CH-1:0]   sgmii_status_set_100,
  input  logic [NUM_CH-1:0]   sgmii_status_set_1000,
  input  logic [NUM_CH-1:0]   status_led_link,
  input  logic [NUM_CH-1:0]   status_led_crs,
  input  logic [NUM_CH-1:0]   status_led_an,
  input  logic [NUM_CH-1:0]   status_led_char_err,
  input  logic [NUM_CH-1:0]   status_led_disp_err,
  output logic [NUM_CH-1:0]   link_up,
  output logic [2*NUM_CH-1:0] speed_code,
  output logic [NUM_CH-1:0]   led_activity,
  output logic                irq,
  input  logic [5:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic [3:0]          csr_byteenable,
  output logic [31:0]         csr_readdata,
  output logic                csr_readdatavalid,
  output logic                csr_waitrequest
);

  localparam int unsigned OFS_W = $clog2(CH_STRIDE);
  localparam int unsigned CH_W  = 5 - OFS_W;

  logic [CNT_W-1:0]  char_cnt [NUM_CH];
  logic [CNT_W-1:0]  disp_cnt [NUM_CH];
  logic [NUM_CH-1:0] link_chg, sat, clr_char, clr_disp;
  logic [CH_W-1:0]   ch_sel;
  logic [OFS_W-1:0]  ofs;
  logic              wr_en, rd_en, ch_space;
  logic [15:0]       int_status, events, w1c;
  logic [31:0]       int_mask, rd_mux;

  assign csr_waitrequest = 1'b0;
  assign wr_en    = csr_write && (csr_byteenable == 4'hF);
  assign rd_en    = csr_read && !csr_write;
  assign ch_space = !csr_address[5];
  assign ch_sel   = csr_address[4:OFS_W];
  assign ofs      = csr_address[OFS_W-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(i);

    assign clr_char[i] = wr_en && ch_space && ch_sel == CH_ID && ofs == OFS_CHAR_ERR;
    assign clr_disp[i] = wr_en && ch_space && ch_sel == CH_ID && ofs == OFS_DISP_ERR;

    sgmii_link_monitor_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk         (csr_clk_clk),
      .rst_n       (rst_in_reset_n),
      .link_raw    (status_led_link[i]),
      .set_10      (sgmii_status_set_10[i]),
      .set_100     (sgmii_status_set_100[i]),
      .set_1000    (sgmii_status_set_1000[i]),
      .crs         (status_led_crs[i]),
      .char_err    (status_led_char_err[i]),
      .disp_err    (status_led_disp_err[i]),
      .clr_char    (clr_char[i]),
      .clr_disp    (clr_disp[i]),
      .link_up     (link_up[i]),
      .speed_code  (speed_code[2*i +: 2]),
      .led_activity(led_activity[i]),
      .char_cnt    (char_cnt[i]),
      .disp_cnt    (disp_cnt[i]),
      .link_chg    (link_chg[i]),
      .sat         (sat[i])
    );
  end

  assign events = {8'(sat), 8'(link_chg)};
  assign w1c    = (wr_en && csr_address == ADDR_INT_STATUS) ? csr_writedata[15:0] : '0;

  // New events are OR'd in after the W1C mask so a same-cycle set wins.
  always_ff @(posedge csr_clk_clk) begin
    if (!rst_in_reset_n) begin
      int_status <= '0;
      int_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      int_status <= (int_status & ~w1c) | events;
      if (wr_en && csr_address == ADDR_INT_MASK)
        int_mask <= csr_writedata;
      irq <= |(int_status & int_mask[15:0]);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (csr_address == ADDR_INT_STATUS) begin
      rd_mux = 32'(int_status);
    end else if (csr_address == ADDR_INT_MASK) begin
      rd_mux = int_mask;
    end else if (ch_space) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_sel == CH_W'(i)) begin
          case (ofs)
            OFS_STATUS:   rd_mux = {27'b0, led_activity[i], status_led_an[i],
                                    speed_code[2*i +: 2], link_up[i]};
            OFS_CHAR_ERR: rd_mux = 32'(char_cnt[i]);
            OFS_DISP_ERR: rd_mux = 32'(disp_cnt[i]);
            default:      rd_mux = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge csr_clk_clk) begin
    if (!rst_in_reset_n) begin
      csr_readdatavalid <= 1'b0;
      csr_readdata      <= '0;
    end else begin
      csr_readdatavalid <= rd_en;
      csr_readdata      <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_sgmii_link_monitor.sv
// Directed bench for sgmii_link_monitor: CSR reads are scoreboarded by a
// separate monitor; status outputs are checked directly after each edge.
module tb_sgmii_link_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s10, s100, s1000, lnk, crs, an, cerr, derr;
  logic [1:0]  link_up, led;
  logic [3:0]  spd;
  logic        irq;
  logic [5:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rdv, wreq;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_e;
  string       mon_n;

  always #5 clk = ~clk;

  sgmii_link_monitor #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(8), .STRETCH_CYCLES(5), .CNT_W(4)
  ) dut (
    .csr_clk_clk          (clk),
    .rst_in_reset_n       (rst_n),
    .sgmii_status_set_10  (s10),
    .sgmii_status_set_100 (s100),
    .sgmii_status_set_1000(s1000),
    .status_led_link      (lnk),
    .status_led_crs       (crs),
    .status_led_an        (an),
    .status_led_char_err  (cerr),
    .status_led_disp_err  (derr),
    .link_up              (link_up),
    .speed_code           (spd),
    .led_activity         (led),
    .irq                  (irq),
    .csr_address          (addr),
    .csr_read             (rd),
    .csr_write            (wr),
    .csr_writedata        (wdata),
    .csr_byteenable       (be),
    .csr_readdata         (rdata),
    .csr_readdatavalid    (rdv),
    .csr_waitrequest      (wreq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic csr_rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    addr = a;
    rd = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    rd = 1'b0;
  endtask

  task automatic csr_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    wdata = d;
    be = b;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  // Scoreboard monitor: every readdatavalid consumes one expected entry.
  always @(posedge clk) begin
    #1;
    if (rdv === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdv got=%0h want=none", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk(mon_n, rdata, mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {s10, s100, s1000, lnk, crs, an, cerr, derr} = '0;
    addr = '0; rd = 0; wr = 0; wdata = '0; be = '0;
    repeat (3) tick();
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_speed", 32'(spd), 32'hF);
    chk("rst_led", 32'(led), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rdv", 32'(rdv), 0);
    rst_n = 1'b1;
    tick();

    // Debounce: 7 cycles is not enough, 8 is.
    csr_wr(6'h21, 32'h1, 4'hF);
    lnk[0] = 1'b1;
    repeat (7) tick();
    chk("deb_short", 32'(link_up[0]), 0);
    lnk[0] = 1'b0;
    tick();
    chk("deb_drop", 32'(link_up[0]), 0);
    lnk[0] = 1'b1;
    repeat (7) tick();
    chk("deb_7", 32'(link_up[0]), 0);
    tick();
    chk("deb_8", 32'(link_up[0]), 1);
    chk("irq_lag", 32'(irq), 0);
    tick();
    chk("irq_set", 32'(irq), 1);
    csr_rd(6'h20, 32'h1, "int_link_chg");
    csr_wr(6'h20, 32'h1, 4'hF);
    chk("irq_hold", 32'(irq), 1);
    tick();
    chk("irq_clr", 32'(irq), 0);

    // W1C on the very edge link_chg[0] sets: set wins.
    lnk[0] = 1'b0;
    repeat (7) tick();
    csr_wr(6'h20, 32'h1, 4'hF);
    chk("race_link", 32'(link_up[0]), 0);
    csr_rd(6'h20, 32'h1, "w1c_race");
    csr_wr(6'h20, 32'hFFFF, 4'hF);

    // Speed decode, one-cycle latency.
    s100[1] = 1'b1;
    chk("spd_latency", 32'(spd[3:2]), 32'h3);
    tick();
    chk("spd_100", 32'(spd[3:2]), 32'h1);
    s100[1] = 1'b0; s10[1] = 1'b1; s1000[1] = 1'b1; s1000[0] = 1'b1; an[1] = 1'b1;
    tick();
    chk("spd_multi", 32'(spd[3:2]), 32'h3);
    chk("spd_1000", 32'(spd[1:0]), 32'h2);
    csr_rd(6'h04, 32'h0000_000E, "status_ch1");
    csr_rd(6'h00, 32'h0000_0004, "status_ch0");
    {s10, s100, s1000, an} = '0;

    // Activity stretch: single pulse, then a retrigger at cycle 3.
    crs[0] = 1'b1;
    tick();
    crs[0] = 1'b0;
    chk("act_rise", 32'(led[0]), 1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("act_hold%0d", k), 32'(led[0]), 1);
    end
    tick();
    chk("act_fall", 32'(led[0]), 0);
    chk("act_ch1", 32'(led[1]), 0);
    crs[0] = 1'b1;
    tick();
    crs[0] = 1'b0;
    tick();
    crs[0] = 1'b1;
    tick();
    crs[0] = 1'b0;
    repeat (4) tick();
    chk("act_ext7", 32'(led[0]), 1);
    tick();
    chk("act_ext8", 32'(led[0]), 0);

    // Saturation, sat interrupt and clear-vs-increment.
    cerr[0] = 1'b1;
    repeat (20) tick();
    cerr[0] = 1'b0;
    csr_rd(6'h01, 32'd15, "char_sat");
    csr_rd(6'h20, 32'h100, "sat_bit");
    chk("sat_masked_irq", 32'(irq), 0);
    csr_wr(6'h01, 32'h0, 4'hF);
    cerr[0] = 1'b1;
    repeat (2) tick();
    csr_wr(6'h01, 32'h0, 4'hF);
    cerr[0] = 1'b0;
    csr_rd(6'h01, 32'd0, "clr_race");
    csr_wr(6'h20, 32'h100, 4'hF);
    csr_rd(6'h20, 32'h0, "sat_w1c");

    // Read during increment returns pre-increment; partial writes ignored.
    derr[1] = 1'b1;
    repeat (3) tick();
    csr_rd(6'h06, 32'd3, "disp_pre_inc");
    derr[1] = 1'b0;
    csr_rd(6'h06, 32'd4, "disp_post");
    csr_wr(6'h06, 32'h0, 4'h7);
    csr_rd(6'h06, 32'd4, "partial_be");
    csr_wr(6'h06, 32'h0, 4'hF);
    csr_rd(6'h06, 32'd0, "disp_clr");

    // Unmapped space, and simultaneous read+write (write only).
    csr_rd(6'h09, 32'h0, "unmapped_ch2");
    csr_rd(6'h03, 32'h0, "reserved");
    csr_rd(6'h22, 32'h0, "unmapped_hi");
    addr = 6'h21; wdata = 32'h3; be = 4'hF; rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    csr_rd(6'h21, 32'h3, "rw_collision");

    // Build up non-reset state, then reset during an outstanding read.
    csr_wr(6'h21, 32'h101, 4'hF);
    lnk[0] = 1'b1; crs[0] = 1'b1; s100[0] = 1'b1; cerr[0] = 1'b1;
    repeat (16) tick();
    cerr[0] = 1'b0;
    tick();
    chk("pre_rst_link", 32'(link_up[0]), 1);
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_spd", 32'(spd[1:0]), 32'h1);
    addr = 6'h21; rd = 1'b1; rst_n = 1'b0;
    tick();
    rd = 1'b0;
    chk("mid_rst_link", 32'(link_up), 0);
    chk("mid_rst_spd", 32'(spd), 32'hF);
    chk("mid_rst_led", 32'(led), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rdv", 32'(rdv), 0);
    repeat (2) tick();
    {lnk, crs, s100} = '0;
    rst_n = 1'b1;
    tick();
    csr_rd(6'h21, 32'h0, "mask_after_rst");
    csr_rd(6'h01, 32'h0, "char_after_rst");
    csr_rd(6'h20, 32'h0, "int_after_rst");
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
